// File: rtl/hyperspace_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// hyperspace_frame_ctrl : frame sequencer gating the GPIO <-> HyperSpace core
// streams. Optional stall timeout: HYPERSPACE_FRAME_CTRL_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module hyperspace_frame_ctrl #(
  parameter int IN_W           = 8,
  parameter int OUT_W          = 16,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_in_len,
  input  logic [CNT_W-1:0] cfg_out_len,
  input  logic [7:0]       cfg_frames,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             c_in_valid,
  input  logic             c_in_ready,
  output logic [IN_W-1:0]  c_in_data,
  output logic             c_in_last,
  input  logic             c_out_valid,
  output logic             c_out_ready,
  input  logic [OUT_W-1:0] c_out_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_last,
  output logic             err_timeout,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IN   = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_in_len;
  logic [CNT_W-1:0] r_out_len;
  logic [7:0]       r_frames;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [7:0]       r_frame_cnt;
  logic             r_err_cfg;
  logic             r_err_last;

  logic             w_active;
  logic             w_in_en;
  logic             w_out_en;
  logic             w_in_last;
  logic             w_out_last;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [CNT_W-1:0] w_in_cnt_nxt;
  logic [CNT_W-1:0] w_out_cnt_nxt;
  logic             w_in_full;
  logic             w_frame_end;
  logic             w_last_frame;
  logic             w_abort;

  assign w_active   = (r_state == ST_IN) || (r_state == ST_OUT);
  assign w_in_en    = (r_state == ST_IN) && (r_in_cnt < r_in_len);
  assign w_out_en   = w_active && (r_out_cnt < r_out_len);
  assign w_in_last  = w_in_en && (r_in_cnt == r_in_len - CNT_W'(1));
  assign w_out_last = w_out_en && (r_out_cnt == r_out_len - CNT_W'(1));
  assign w_in_hs    = s_valid & c_in_ready & w_in_en;
  assign w_out_hs   = c_out_valid & m_ready & w_out_en;

  assign w_in_cnt_nxt  = r_in_cnt + CNT_W'(w_in_hs);
  assign w_out_cnt_nxt = r_out_cnt + CNT_W'(w_out_hs);

  // The cycle after the last input beat (in_cnt == in_len) is the transition
  // cycle; the frame closes there if the output side is also complete.
  assign w_in_full    = (r_in_cnt == r_in_len);
  assign w_frame_end  = (((r_state == ST_IN) && w_in_full) || (r_state == ST_OUT))
                        && (w_out_cnt_nxt == r_out_len);
  assign w_last_frame = (r_frames != 8'd0) && ((r_frame_cnt + 8'd1) == r_frames);

  assign c_in_valid  = s_valid & w_in_en;
  assign s_ready     = c_in_ready & w_in_en;
  assign c_in_data   = s_data;
  assign c_in_last   = w_in_last;
  assign m_valid     = c_out_valid & w_out_en;
  assign c_out_ready = m_ready & w_out_en;
  assign m_data      = c_out_data;
  assign m_last      = w_out_last;

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err_cfg   = r_err_cfg;
  assign err_last  = r_err_last;
  assign frame_cnt = r_frame_cnt;

`ifdef HYPERSPACE_FRAME_CTRL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_err_timeout;
  logic               w_timeout;

  assign w_timeout = w_active && !w_in_hs && !w_out_hs
                     && (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
  assign w_abort     = cfg_abort | w_timeout;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clock) begin
    if (RSTB) begin
      r_stall       <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && cfg_start) begin
        r_err_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (w_active && !w_in_hs && !w_out_hs && !w_abort) begin
        r_stall <= r_stall + STALL_W'(1);
      end else begin
        r_stall <= '0;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_abort          = cfg_abort;
  assign err_timeout      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (RSTB) begin
      r_state     <= ST_IDLE;
      r_in_len    <= '0;
      r_out_len   <= '0;
      r_frames    <= 8'd0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_frame_cnt <= 8'd0;
      r_err_cfg   <= 1'b0;
      r_err_last  <= 1'b0;
    end else begin
      if (w_in_hs && (s_last != w_in_last)) begin
        r_err_last <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_in_len    <= cfg_in_len;
            r_out_len   <= cfg_out_len;
            r_frames    <= cfg_frames;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_frame_cnt <= 8'd0;
            r_err_last  <= 1'b0;
            if ((cfg_in_len == '0) || (cfg_out_len == '0)) begin
              r_err_cfg <= 1'b1;
            end else begin
              r_err_cfg <= 1'b0;
              r_state   <= ST_IN;
            end
          end
        end
        ST_IN, ST_OUT: begin
          if (w_abort) begin
            r_state   <= ST_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_state     <= w_last_frame ? ST_DONE : ST_IN;
          end else begin
            r_in_cnt  <= w_in_cnt_nxt;
            r_out_cnt <= w_out_cnt_nxt;
            if ((r_state == ST_IN) && w_in_full) begin
              r_state <= ST_OUT;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/hyperspace_frame_ctrl.md
# hyperspace_frame_ctrl

Frame sequencer between the GPIO stream pins and the HyperSpace core. Latches the per-frame input and output beat counts, runs a programmed number of frames, and gates the 8-bit input stream and the 16-bit output stream. It generates the core-side `in_last` and the sink-side `last` from its own counters, and flags any upstream `last` mismatch. Both stream paths are zero-latency combinational pass-throughs; all control is in a small FSM with counters.

## Interface
Parameters:
- IN_W, 8, input sample width
- OUT_W, 16, output sample width
- CNT_W, 16, beat counter and length width
- TIMEOUT_CYCLES, 4096, stall limit (used only with the timeout feature)

Ports:
- clock  in  1  clock
- RSTB  in  1  reset, synchronous, active-high
- cfg_start  in  1  one-cycle pulse that starts a run
- cfg_abort  in  1  one-cycle pulse that aborts a run
- cfg_in_len  in  CNT_W  input beats per frame (default use 2048)
- cfg_out_len  in  CNT_W  output beats per frame (default use 512)
- cfg_frames  in  8  number of frames; 0 = run until abort
- s_valid / s_ready / s_data / s_last  in/out/in/in  1/1/IN_W/1  upstream input stream
- c_in_valid / c_in_ready / c_in_data / c_in_last  out/in/out/out  1/1/IN_W/1  core input
- c_out_valid / c_out_ready / c_out_data  in/out/in  1/1/OUT_W  core output
- m_valid / m_ready / m_data / m_last  out/in/out/out  1/1/OUT_W/1  downstream output stream
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a run
- err_cfg, err_last, err_timeout  out  1 each  sticky error flags
- frame_cnt  out  8  number of completed frames in the current run

## Operation
**States:** IDLE, IN, OUT, DONE.

**IDLE**
- On `cfg_start`, latch all three cfg inputs, clear the counters, clear `frame_cnt`, then go to IN.
- If the latched `in_len` is 0 or `out_len` is 0, stay in IDLE and set `err_cfg`.
- `cfg_start` is ignored in every other state.

**Path enables**
- `in_en = (state==IN) && (in_cnt < in_len)`.
- `out_en = (state==IN || state==OUT) && (out_cnt < out_len)`.

**Pass-through (combinational)**
- `c_in_valid = s_valid & in_en`
- `s_ready = c_in_ready & in_en`
- `c_in_data = s_data`
- `c_in_last = in_en & (in_cnt == in_len-1)`
- `m_valid = c_out_valid & out_en`
- `c_out_ready = m_ready & out_en`
- `m_data = c_out_data`
- `m_last = out_en & (out_cnt == out_len-1)`

**Counters**
- `in_cnt` increments on each input handshake.
- `out_cnt` increments on each output handshake.
- Both counters saturate at their latched length.

**Last checking**
- On an input handshake, `s_last` must equal `c_in_last`.
- On a mismatch, set `err_last`. The frame still uses the local count.

**Transitions**
- IN → OUT when `in_cnt` reaches `in_len`.
- If `out_cnt` has already reached `out_len` in the same cycle, complete the frame directly instead of entering OUT.
- OUT: frame completes when `out_cnt` reaches `out_len`. On completion:
  - `frame_cnt` increments and both counters clear.
  - If `frames != 0` and `frame_cnt+1 == frames`, go to DONE; otherwise go to IN.
- DONE: assert `done` for one cycle, then go to IDLE.

**Abort and reset**
- `cfg_abort` in IN or OUT: go to IDLE next cycle, clear both counters, no `done` pulse. Error flags are held.
- `cfg_abort` and a frame completion in the same cycle: abort wins.
- Sticky error flags clear only on RSTB or on an accepted `cfg_start`.
- RSTB mid-frame: all state is dropped immediately. Beats already passed to the core are not recovered.

## Timing
- Stream latency is 0 cycles; data is combinational from input to output.
- The handshake occurs in any cycle where valid and ready are both high. valid must not depend on ready.
- The state update, `frame_cnt` update and `done` pulse occur on the clock edge after the final handshake.
- Between frames there is exactly 1 cycle with `in_en = 0` (the transition cycle). Input throughput stays 1 beat/cycle within a frame.
- `cfg_start` to first possible input handshake: 1 cycle.
- Reset values:
  - state IDLE, counters 0, `frame_cnt` 0.
  - `done`, `busy`, `err_*` all 0.
  - `s_ready`, `c_in_valid`, `c_in_last`, `m_valid`, `m_last`, `c_out_ready` all 0.

## Configuration
- Macro: `HYPERSPACE_FRAME_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A stall counter runs in IN and OUT. It clears on any input or output handshake.
  - On reaching TIMEOUT_CYCLES, set `err_timeout` and abort to IDLE. This has the same effect as `cfg_abort`, with no `done` pulse.
- **Undefined:** no stall counter is built, `err_timeout` is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- **Single frame:** lengths 2048/512, frames=1, always-ready source and sink.
  - Required: `c_in_last` high on input beat 2047 only.
  - Required: `m_last` high on output beat 511 only.
  - Required: `done` pulses once; `frame_cnt` = 1; no errors.
- **Backpressure:** random `c_in_ready` and `m_ready` at 50%.
  - Required: no data dropped or duplicated; sequence matches the golden model; `done` pulses after exactly 2048/512 beats.
- **Multi-frame:** frames=3.
  - Required: three `c_in_last` and three `m_last` pulses; `frame_cnt` steps 1, 2, 3; a single `done`.
  - Required: `s_ready` is low for exactly 1 cycle between frames.
- **Last mismatch:** `s_last` driven high on beat 100.
  - Required: `err_last` set.
  - Required: the frame still ends at beat 2047 and `done` still pulses.
- **Abort and bad config:**
  - `cfg_abort` at input beat 1000: `busy` drops next cycle and `s_ready` = 0 with no `done`; a restart then completes normally.
  - `cfg_start` with `cfg_in_len` = 0: `err_cfg` = 1 and `busy` stays 0.
- **Timeout (macro defined):** TIMEOUT_CYCLES = 64, `m_ready` held low in OUT.
  - Required: `err_timeout` = 1 and state is IDLE after 64 stalled cycles.
  - With the macro undefined, the controller stays in OUT indefinitely.
